// File: rtl/cnn_pkg.sv
// cnn_pkg: shared tag codes, framer states and IF word type (rev 1.0)
`default_nettype none

package cnn_pkg;

  localparam int PIXEL_W = 16;

  localparam logic [1:0] TAG_START  = 2'b10;
  localparam logic [1:0] TAG_END    = 2'b01;
  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [PIXEL_W+1:0] if_word_t;

  // A one-pixel row is both first and last, which yields TAG_SINGLE.
  function automatic logic [1:0] frame_tag(input logic first, input logic last);
    case ({first, last})
      2'b11:   frame_tag = TAG_SINGLE;
      2'b10:   frame_tag = TAG_START;
      2'b01:   frame_tag = TAG_END;
      default: frame_tag = TAG_MID;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_out_reg.sv
// if_out_reg: one-entry output holding register draining into a FIFO under full backpressure (rev 1.0)
`default_nettype none

module if_out_reg #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         full,
  output logic         wen,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         can_load
);

  logic [W-1:0] word;

  assign wen      = valid && !full;
  assign dout     = word;
  // Loading while the held word drains keeps one word per cycle with no bubble.
  assign can_load = !valid || !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
    end else if (wen) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifmap_row_framer.sv
// ifmap_row_framer: tags a raw pixel stream with row start/end framing for the IF FIFO (rev 1.0)
`default_nettype none

module ifmap_row_framer
  import cnn_pkg::*;
#(
  parameter int IF_SCRATCH_WIDTH = PIXEL_W,
  parameter int ROW_LEN_W        = 6,
  parameter int ROW_CNT_W        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROW_LEN_W-1:0]        row_len,
  input  logic [ROW_CNT_W-1:0]        num_rows,
  input  logic                        in_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0] in_data,
  output logic                        in_ready,
  input  logic                        IF_full,
  output logic                        IF_wen,
  output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
  output logic                        busy,
  output logic                        done
);

  state_t                      state, state_nxt;
  logic [ROW_LEN_W-1:0]        row_len_q, col;
  logic [ROW_CNT_W-1:0]        num_rows_q, row;
  logic                        col_last, row_last, xfer;
  logic                        out_valid, can_load;
  logic [IF_SCRATCH_WIDTH+1:0] load_word;

  assign col_last  = (col == row_len_q - ROW_LEN_W'(1));
  assign row_last  = (row == num_rows_q - ROW_CNT_W'(1));
  assign xfer      = in_valid && in_ready;
  assign load_word = {frame_tag(col == '0, col_last), in_data};

  if_out_reg #(
    .W (IF_SCRATCH_WIDTH + 2)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_word (load_word),
    .full      (IF_full),
    .wen       (IF_wen),
    .dout      (IF_din),
    .valid     (out_valid),
    .can_load  (can_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (row_len == '0 || num_rows == '0) ? DONE : RUN;
      RUN:     if (xfer && col_last && row_last) state_nxt = DRAIN;
      DRAIN:   if (IF_wen) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && can_load;
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  // Config is captured only at an accepted start so mid-frame changes are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_len_q  <= '0;
      num_rows_q <= '0;
      col        <= '0;
      row        <= '0;
    end else if (state == IDLE && start) begin
      row_len_q  <= row_len;
      num_rows_q <= num_rows;
      col        <= '0;
      row        <= '0;
    end else if (xfer) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_CNT_W'(1);
      end else begin
        col <= col + ROW_LEN_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
